tt_sweep_ctrl: RTL

Sequencer that exercises one N_IN-input, single-output combinational gate netlist from the ABC design set across its full truth table and checks the result against an expected truth-table word. It drives the gate's inputs, waits a programmable settle time per vector, captures the gate output bit by bit, and reports the captured table, a mismatch mask, the first failing index and pass/fail. It sits between the test or configuration host and an instantiated gate netlist, and serialises all access to that gate's inputs.

---
 rtl/tt_sweep_pkg.sv | 19 +
 rtl/tt_lsb_find.sv | 24 ++
 rtl/tt_sweep_ctrl.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/tt_sweep_pkg.sv
// Shared types and constants for the truth-table sweep sequencer.
// T (table width) is always derived from the gate input count with tt_width().
package tt_sweep_pkg;

  localparam int DEF_N_IN   = 4;
  localparam int DEF_SETTLE = 3;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_SAMPLE = 2'd2,
    ST_DONE   = 2'd3
  } sweep_state_t;

  function automatic int tt_width(input int n_in);
    return 1 << n_in;
  endfunction

endpackage

// File: rtl/tt_lsb_find.sv
// Lowest-set-bit encoder: reports the index of the lowest set bit of vec,
// and whether any bit is set at all (idx is 0 when none is).
module tt_lsb_find #(
  parameter int IW = 4,
  parameter int W  = 1 << IW
) (
  input  logic [W-1:0]  vec,
  output logic [IW-1:0] idx,
  output logic          valid
);

  // Scanning from the top down lets the lowest set bit overwrite last.
  always_comb begin
    idx   = '0;
    valid = 1'b0;
    for (int i = W - 1; i >= 0; i--) begin
      if (vec[i]) begin
        idx   = IW'(i);
        valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/tt_sweep_ctrl.sv
// Walks a combinational gate through every input vector, holds each for SETTLE+1
// cycles, captures the output bit and compares the table against an expected word.
module tt_sweep_ctrl
  import tt_sweep_pkg::*;
#(
  parameter int  N_IN   = DEF_N_IN,
  parameter int  SETTLE = DEF_SETTLE,
  localparam int T      = tt_width(N_IN)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            abort,
  input  logic [T-1:0]    expect_tt,
  output logic [N_IN-1:0] gate_in,
  input  logic            gate_out,
  output logic            busy,
  output logic            done,
  output logic            aborted,
  output logic            pass,
  output logic [T-1:0]    captured_tt,
  output logic [T-1:0]    mismatch,
  output logic [N_IN-1:0] fail_idx,
  output logic            fail_valid,
  output logic [1:0]      state_dbg
);

  // Handshake: start is a level sampled only in IDLE (one accepted edge begins a
  // sweep); abort is a level sampled only in SETTLE/SAMPLE; done and aborted are
  // single-cycle registered pulses, and results hold until the next accepted start.

  localparam int              CW       = $clog2(SETTLE) + 1;
  localparam logic [CW-1:0]   CNT_LOAD = CW'(SETTLE - 1);
  localparam logic [N_IN-1:0] LAST_IDX = N_IN'(T - 1);

  sweep_state_t    state;
  logic [N_IN-1:0] idx;
  logic [CW-1:0]   cnt;
  logic [T-1:0]    exp_q;
  logic [T-1:0]    cap_next;
  logic [T-1:0]    mism_next;
  logic [N_IN-1:0] lsb_idx;
  logic            lsb_valid;

  // The vector index register drives the gate directly, so gate_in is glitch-free.
  assign gate_in   = idx;
  assign state_dbg = state;

  // Table as it will look once the current sample lands; results use this so they
  // are valid in the same cycle done is raised.
  always_comb begin
    cap_next      = captured_tt;
    cap_next[idx] = gate_out;
  end

  assign mism_next = cap_next ^ exp_q;

  tt_lsb_find #(
    .IW (N_IN),
    .W  (T)
  ) u_lsb_find (
    .vec   (mism_next),
    .idx   (lsb_idx),
    .valid (lsb_valid)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ST_IDLE;
      idx         <= '0;
      cnt         <= '0;
      exp_q       <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      aborted     <= 1'b0;
      pass        <= 1'b0;
      captured_tt <= '0;
      mismatch    <= '0;
      fail_idx    <= '0;
      fail_valid  <= 1'b0;
    end else begin
      done    <= 1'b0;
      aborted <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            exp_q       <= expect_tt;
            idx         <= '0;
            cnt         <= CNT_LOAD;
            captured_tt <= '0;
            mismatch    <= '0;
            pass        <= 1'b0;
            fail_idx    <= '0;
            fail_valid  <= 1'b0;
            busy        <= 1'b1;
            state       <= ST_SETTLE;
          end
        end

        ST_SETTLE: begin
          if (abort) begin
            idx     <= '0;
            busy    <= 1'b0;
            aborted <= 1'b1;
            state   <= ST_IDLE;
          end else if (cnt == '0) begin
            state <= ST_SAMPLE;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end

        ST_SAMPLE: begin
          // An abort here discards the in-flight sample; earlier bits are kept.
          if (abort) begin
            idx     <= '0;
            busy    <= 1'b0;
            aborted <= 1'b1;
            state   <= ST_IDLE;
          end else begin
            captured_tt <= cap_next;
            if (idx == LAST_IDX) begin
              pass       <= (cap_next == exp_q);
              mismatch   <= mism_next;
              fail_idx   <= lsb_idx;
              fail_valid <= lsb_valid;
              done       <= 1'b1;
              state      <= ST_DONE;
            end else begin
              idx   <= idx + 1'b1;
              cnt   <= CNT_LOAD;
              state <= ST_SETTLE;
            end
          end
        end

        ST_DONE: begin
          busy  <= 1'b0;
          state <= ST_IDLE;
        end

        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
